mux_2to1_6bit: RTL and testbench
================================

// Module: mux_2to1_6bit
// PURPOSE
//   Registered 2-to-1 data selector for the 6-bit datapath.
//   Picks i0 or i1 with sel and presents the result on out one clock later.
//   Used wherever two 6-bit sources (register file, immediate, ALU result)
//   feed a single consumer. The output register gives the CPU a clean,
//   glitch-free selected value.
// PARAMETERS
//   WIDTH     6   data width of i0, i1, out
//   RESET_VAL 0   value loaded into out on reset (WIDTH bits)
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst      in   1      synchronous, active-high reset
//   i0       in   WIDTH  data input, selected when sel=0
//   i1       in   WIDTH  data input, selected when sel=1
//   sel      in   1      select: 0 -> i0, 1 -> i1
//   en       in   1      update enable; 0 holds out/sel_q
//   out      out  WIDTH  registered selected data
//   sel_q    out  1      sel value captured with current out
//   sel_chg  out  1      1-cycle pulse: captured sel differs from previous sel_q
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous, active-high.
//   - Reset (rst=1 at rising edge): out<=RESET_VAL, sel_q<=0, sel_chg<=0.
//     rst has priority over en and all data inputs.
//   - Normal (rst=0, en=1), every rising edge:
//       out   <= (sel==1'b1) ? i1 : i0;
//       sel_q <= sel;
//       sel_chg <= (sel != sel_q);
//   - Hold (rst=0, en=0): out and sel_q keep their values; sel_chg<=0.
//   - Latency: exactly 1 clk from i0/i1/sel/en change to out change.
//     No combinational path from any input to any output.
//   - Width rules: pure bit-wise selection, no arithmetic, no truncation.
//     All WIDTH bits pass unchanged, e.g. 6'b111111 stays 6'b111111.
//   - sel X/Z (simulation only): treated as 0, so i0 is selected.
//     Out never goes X because of sel.
//   - i0 == i1: out equals that value regardless of sel.
//     sel_chg still follows sel toggles.
//   - Input changes between edges have no effect until the next edge.
//   - Reset mid-operation: out returns to RESET_VAL on that edge.
//     The first post-reset sel=1 capture raises sel_chg for one cycle.
// TESTING
//   1. Reset: rst=1 for 2 cycles, i0=5, i1=9 -> out=0, sel_q=0, sel_chg=0.
//   2. Select i0: i0=0, i1=8, sel=0, en=1 -> out=6'b000000 after 1 edge.
//   3. Select i1: then sel=1 -> out=6'b001000 on next edge.
//      sel_q=1; sel_chg=1 for exactly one cycle.
//   4. Hold: en=0, change i1 to 63 and sel to 0 -> out stays 8.
//      sel_chg=0. With en=1, next edge gives out=0.
//   5. Full width: i0=6'b101010, i1=6'b010101, alternate sel every cycle.
//      out alternates with 1-cycle lag; sel_chg=1 every cycle.
//   6. Reset priority: rst=1 with en=1, sel=1, i1=63 -> out=0 on that edge.

Source files
------------

// File: rtl/mux_2to1_6bit.sv
// Registered 2-to-1 selector with captured select and a select-change pulse.
// All outputs come from flops; nothing passes combinationally from input to output.
module mux_2to1_6bit #(
  parameter int unsigned          WIDTH     = 6,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             sel_q,
  output logic             sel_chg
);

  logic             sel_n;
  logic [WIDTH-1:0] data_n;

  // An unknown sel falls into the else branch, so it resolves to 0 / i0
  // and neither out nor sel_q can pick up an X from it.
  always_comb begin
    sel_n  = 1'b0;
    data_n = i0;
    if (sel) begin
      sel_n  = 1'b1;
      data_n = i1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= RESET_VAL;
      sel_q   <= 1'b0;
      sel_chg <= 1'b0;
    end else if (en) begin
      out     <= data_n;
      sel_q   <= sel_n;
      sel_chg <= (sel_n != sel_q);
    end else begin
      sel_chg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_2to1_6bit.sv
// Directed-vector bench for mux_2to1_6bit: stimulus pushes hand-computed
// expectations into a queue, an independent monitor pops and compares.
module tb_mux_2to1_6bit;

  logic       clk;
  logic       rst;
  logic [5:0] i0;
  logic [5:0] i1;
  logic       sel;
  logic       en;
  logic [5:0] out;
  logic       sel_q;
  logic       sel_chg;

  typedef struct {
    logic [5:0] out;
    logic       sq;
    logic       chg;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;
  bit   done   = 1'b0;

  mux_2to1_6bit #(.WIDTH(6), .RESET_VAL(6'd0)) dut (
    .clk     (clk),
    .rst     (rst),
    .i0      (i0),
    .i1      (i1),
    .sel     (sel),
    .en      (en),
    .out     (out),
    .sel_q   (sel_q),
    .sel_chg (sel_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the expectation covers the next rising edge.
  task automatic apply(input logic r, input logic e, input logic s,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [5:0] eo, input logic esq, input logic ech);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sel = s; i0 = a0; i1 = a1;
    vec_id++;
    x.out = eo; x.sq = esq; x.chg = ech; x.id = vec_id;
    exp_q.push_back(x);
  endtask

  // Monitor: every rising edge with a pending expectation produces one result.
  initial begin
    exp_t x;
    while (!done) begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (out !== x.out) begin
          errors++;
          $display("FAIL out vec%0d: got %b expected %b", x.id, out, x.out);
        end
        checks++;
        if (sel_q !== x.sq) begin
          errors++;
          $display("FAIL sel_q vec%0d: got %b expected %b", x.id, sel_q, x.sq);
        end
        checks++;
        if (sel_chg !== x.chg) begin
          errors++;
          $display("FAIL sel_chg vec%0d: got %b expected %b", x.id, sel_chg, x.chg);
        end
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1; en = 1'b0; sel = 1'b0; i0 = '0; i1 = '0;
    //     rst  en   sel  i0          i1          out         sel_q sel_chg
    apply(1'b1, 1'b0, 1'b0, 6'd5,      6'd9,      6'd0,       1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 6'd5,      6'd9,      6'd0,       1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 6'd0,      6'd8,      6'd0,       1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 6'd0,      6'd8,      6'd8,       1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 6'd0,      6'd8,      6'd8,       1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 6'd0,      6'd63,     6'd8,       1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 6'd0,      6'd63,     6'd8,       1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 6'd0,      6'd63,     6'd0,       1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 6'b101010, 6'b010101, 6'b010101,  1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 6'b101010, 6'b010101, 6'b101010,  1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b1, 6'b101010, 6'b010101, 6'b010101,  1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 6'b101010, 6'b010101, 6'b101010,  1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 6'b111111, 6'b111111, 6'b111111,  1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 6'b111111, 6'b111111, 6'b111111,  1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 6'd0,      6'd63,     6'd0,       1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 6'd3,      6'd17,     6'd17,      1'b1, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 6'd3,      6'd17,     6'd17,      1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 6'd3,      6'd0,      6'd0,       1'b1, 1'b0);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
